// File: rtl/vec_pkg.sv
// Shared definitions for the vector memory-access stage (load and store paths).
// Geometry defaults, memory opcodes and the store-unit state type.
package vec_pkg;

    localparam int LANES  = 8;
    localparam int BEATS  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int TAG_W  = 4;

    localparam logic [6:0] OP_VLOAD  = 7'b0000111;
    localparam logic [6:0] OP_VSTORE = 7'b0100111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } vst_state_t;

endpackage

// File: rtl/vec_store_unit_if.sv
// Request, data-memory write port and completion signals of the vector store unit.
// The slave modport is the unit; master is the issue side together with the memory.
interface vec_store_unit_if #(
    parameter int LANES  = vec_pkg::LANES,
    parameter int BEATS  = vec_pkg::BEATS,
    parameter int DATA_W = vec_pkg::DATA_W,
    parameter int ADDR_W = vec_pkg::ADDR_W,
    parameter int TAG_W  = vec_pkg::TAG_W
);
    logic                            st_valid;
    logic                            st_ready;
    logic [TAG_W-1:0]                st_tag;
    logic [BEATS*ADDR_W-1:0]         st_addr;
    logic [BEATS*LANES*DATA_W-1:0]   st_data;
    logic [BEATS*LANES-1:0]          st_mask;

    logic                            mem_wr_valid;
    logic                            mem_wr_ready;
    logic [ADDR_W-1:0]               mem_wr_addr;
    logic [LANES*DATA_W-1:0]         mem_wr_data;
    logic [LANES-1:0]                mem_wr_be;

    logic                            done_valid;
    logic [TAG_W-1:0]                done_tag;
    logic                            busy;

    modport master (
        output st_valid, st_tag, st_addr, st_data, st_mask, mem_wr_ready,
        input  st_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_be,
        input  done_valid, done_tag, busy
    );

    modport slave (
        input  st_valid, st_tag, st_addr, st_data, st_mask, mem_wr_ready,
        output st_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_be,
        output done_valid, done_tag, busy
    );
endinterface

// File: rtl/vec_store_unit.sv
// Vector store unit: captures one store, writes it as BEATS row beats of LANES
// elements each (same element order as the load path), then pulses completion.
//
//   state | meaning
//   IDLE  | ready for a new store request
//   WRITE | issuing beats; beats with an all-zero mask slice are skipped
//   DONE  | one-cycle completion pulse with the captured tag
module vec_store_unit
    import vec_pkg::*;
#(
    parameter int LANES  = vec_pkg::LANES,
    parameter int BEATS  = vec_pkg::BEATS,
    parameter int DATA_W = vec_pkg::DATA_W,
    parameter int ADDR_W = vec_pkg::ADDR_W,
    parameter int TAG_W  = vec_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    vec_store_unit_if.slave  bus
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    vst_state_t                      r_state;
    logic [BW-1:0]                   r_beat;
    logic [TAG_W-1:0]                r_tag;
    logic [BEATS*ADDR_W-1:0]         r_addr;
    logic [BEATS*LANES*DATA_W-1:0]   r_data;
    logic [BEATS*LANES-1:0]          r_mask;

    logic                            r_wr_valid;
    logic [ADDR_W-1:0]               r_wr_addr;
    logic [LANES*DATA_W-1:0]         r_wr_data;
    logic [LANES-1:0]                r_wr_be;
    logic                            r_done_valid;
    logic [TAG_W-1:0]                r_done_tag;

    vst_state_t                      w_state_nxt;
    logic [BW-1:0]                   w_beat_nxt;
    logic                            w_capture;
    logic                            w_load;
    logic                            w_finish;
    logic [BW-1:0]                   w_load_beat;

    logic [BEATS*ADDR_W-1:0]         w_src_addr;
    logic [BEATS*LANES*DATA_W-1:0]   w_src_data;
    logic [BEATS*LANES-1:0]          w_src_mask;
    logic [ADDR_W-1:0]               w_beat_addr;
    logic [LANES*DATA_W-1:0]         w_beat_data;
    logic [LANES-1:0]                w_beat_mask;

    logic                            w_wr_valid_nxt;
    logic [ADDR_W-1:0]               w_wr_addr_nxt;
    logic [LANES*DATA_W-1:0]         w_wr_data_nxt;
    logic [LANES-1:0]                w_wr_be_nxt;
    logic                            w_done_valid_nxt;
    logic [TAG_W-1:0]                w_done_tag_nxt;

    // A held beat (valid high) only moves on ready; a skipped beat moves after one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_load_beat = r_beat;
        case (r_state)
            IDLE: begin
                if (bus.st_valid) begin
                    w_capture   = 1'b1;
                    w_load      = 1'b1;
                    w_load_beat = '0;
                    w_beat_nxt  = '0;
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!r_wr_valid || bus.mem_wr_ready) begin
                    if (r_beat == LAST_BEAT) begin
                        w_finish    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_load_beat = r_beat + 1'b1;
                        w_beat_nxt  = r_beat + 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The first beat is built straight from the request so it is valid in cycle 1.
    assign w_src_addr = w_capture ? bus.st_addr : r_addr;
    assign w_src_data = w_capture ? bus.st_data : r_data;
    assign w_src_mask = w_capture ? bus.st_mask : r_mask;

    assign w_beat_addr = w_src_addr[int'(w_load_beat)*ADDR_W +: ADDR_W];
    assign w_beat_data = w_src_data[int'(w_load_beat)*LANES*DATA_W +: LANES*DATA_W];
    assign w_beat_mask = w_src_mask[int'(w_load_beat)*LANES +: LANES];

    always_comb begin
        w_wr_valid_nxt   = r_wr_valid;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_wr_be_nxt      = r_wr_be;
        w_done_valid_nxt = 1'b0;
        w_done_tag_nxt   = r_done_tag;
        if (w_load) begin
            w_wr_valid_nxt = |w_beat_mask;
            w_wr_addr_nxt  = w_beat_addr;
            w_wr_data_nxt  = w_beat_data;
            w_wr_be_nxt    = w_beat_mask;
        end else if (w_finish) begin
            w_wr_valid_nxt   = 1'b0;
            w_wr_be_nxt      = '0;
            w_done_valid_nxt = 1'b1;
            w_done_tag_nxt   = r_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_tag        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_mask       <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_be      <= '0;
            r_done_valid <= 1'b0;
            r_done_tag   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_wr_valid   <= w_wr_valid_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_wr_be      <= w_wr_be_nxt;
            r_done_valid <= w_done_valid_nxt;
            r_done_tag   <= w_done_tag_nxt;
            if (w_capture) begin
                r_tag  <= bus.st_tag;
                r_addr <= bus.st_addr;
                r_data <= bus.st_data;
                r_mask <= bus.st_mask;
            end
        end
    end

    assign bus.st_ready     = (r_state == IDLE);
    assign bus.busy         = (r_state != IDLE);
    assign bus.mem_wr_valid = r_wr_valid;
    assign bus.mem_wr_addr  = r_wr_addr;
    assign bus.mem_wr_data  = r_wr_data;
    assign bus.mem_wr_be    = r_wr_be;
    assign bus.done_valid   = r_done_valid;
    assign bus.done_tag     = r_done_tag;

endmodule
